cpu_step_controller: RTL

CPU_STEP_CONTROLLER -- requirements
Module: cpu_step_controller

---
 rtl/cpu_ctrl_pkg.sv | 22 ++
 rtl/btn_debounce.sv | 84 ++++++++
 rtl/cpu_step_controller.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/cpu_ctrl_pkg.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Package     : cpu_ctrl_pkg                                             |
// | Description : Shared definitions for the CPU step controller: FSM      |
// |               state encoding and default debounce length.              |
// | Revision    : 1.0 - initial release                                    |
// +------------------------------------------------------------------------+
package cpu_ctrl_pkg;

  // Controller states. The encoding is visible on the state output port.
  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    RUN       = 2'd1,
    STEP_WAIT = 2'd2,
    HALTED    = 2'd3
  } cpu_state_t;

  // Default debounce length. At a 50 MHz board clock this is 10 ms.
  localparam logic [19:0] c_debounce_cycles_default = 20'd500000;

endpackage : cpu_ctrl_pkg
`default_nettype wire

// File: rtl/btn_debounce.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : btn_debounce                                             |
// | Description : Synchronizes a raw push-button, filters contact bounce   |
// |               and emits a one-cycle pulse on each debounced press.     |
// | Revision    : 1.0 - initial release                                    |
// +------------------------------------------------------------------------+
// | Ports                                                                  |
// |   clock_in  in   board clock, all flops on its rising edge             |
// |   reset_n   in   asynchronous active-low reset                         |
// |   btn_raw   in   raw, bouncing button level                            |
// |   btn_press out  one-cycle pulse on each debounced 0->1 transition     |
// +------------------------------------------------------------------------+
module btn_debounce
  import cpu_ctrl_pkg::*;
#(
  parameter logic [19:0] DEBOUNCE_CYCLES = c_debounce_cycles_default,
  parameter int          SYNC_STAGES     = 2
) (
  input  logic clock_in,
  input  logic reset_n,
  input  logic btn_raw,
  output logic btn_press
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic [19:0]            r_count;
  logic                   r_level;
  logic                   r_press;

  logic                   w_btn_sync;
  logic                   w_differs;
  logic                   w_expired;

  generate
    if (SYNC_STAGES > 1) begin : g_sync_chain
      always_ff @(posedge clock_in or negedge reset_n) begin
        if (!reset_n) begin
          r_sync <= '0;
        end else begin
          r_sync <= {r_sync[SYNC_STAGES-2:0], btn_raw};
        end
      end
    end else begin : g_sync_single
      always_ff @(posedge clock_in or negedge reset_n) begin
        if (!reset_n) begin
          r_sync <= '0;
        end else begin
          r_sync <= btn_raw;
        end
      end
    end
  endgenerate

  assign w_btn_sync = r_sync[SYNC_STAGES-1];
  assign w_differs  = (w_btn_sync != r_level);
  // The counter holds the number of differing cycles already seen, so the
  // level flips on the DEBOUNCE_CYCLES-th consecutive differing cycle.
  assign w_expired  = (r_count == (DEBOUNCE_CYCLES - 20'd1));

  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      r_count <= '0;
      r_level <= 1'b0;
      r_press <= 1'b0;
    end else begin
      r_press <= 1'b0;
      if (!w_differs) begin
        // Any reversion to the accepted level restarts the qualification.
        r_count <= '0;
      end else if (w_expired) begin
        r_count <= '0;
        r_level <= w_btn_sync;
        r_press <= w_btn_sync;
      end else begin
        r_count <= r_count + 20'd1;
      end
    end
  end

  assign btn_press = r_press;

endmodule : btn_debounce
`default_nettype wire

// File: rtl/cpu_step_controller.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : cpu_step_controller                                      |
// | Description : Generates single-cycle CPU clock enables from a slow     |
// |               divided clock, in free-run or single-step mode, with     |
// |               halt handling and an issued-pulse counter.               |
// | Revision    : 1.0 - initial release                                    |
// +------------------------------------------------------------------------+
// | Ports                                                                  |
// |   clock_in    in   board clock, the only clock domain                  |
// |   reset_n     in   asynchronous active-low reset                       |
// |   slow_clk    in   divided clock, sampled as data only                 |
// |   run_mode    in   1 = free-run, 0 = single-step                       |
// |   step_btn    in   raw push-button                                     |
// |   halt        in   CPU halt indication                                 |
// |   cpu_en      out  one-cycle CPU clock-enable pulse                    |
// |   cycle_count out  number of cpu_en pulses issued (wraps)              |
// |   state       out  registered FSM state                                |
// +------------------------------------------------------------------------+
module cpu_step_controller
  import cpu_ctrl_pkg::*;
#(
  parameter logic [19:0] DEBOUNCE_CYCLES = c_debounce_cycles_default,
  parameter int          SYNC_STAGES     = 2
) (
  input  logic        clock_in,
  input  logic        reset_n,
  input  logic        slow_clk,
  input  logic        run_mode,
  input  logic        step_btn,
  input  logic        halt,
  output logic        cpu_en,
  output logic [15:0] cycle_count,
  output logic [1:0]  state
);

  // Synchronizer bus: {valid marker, halt, run_mode, slow_clk}. The constant
  // 1 in the top bit tells when the chain holds real samples rather than
  // reset values, so a slow_clk held high through reset is not taken as a
  // fresh rising edge.
  logic [3:0]                  w_sync_in;
  logic [SYNC_STAGES-1:0][3:0] r_sync;
  logic                        w_sync_valid;
  logic                        w_halt_s;
  logic                        w_run_s;
  logic                        w_slow_s;

  logic                        r_slow_prev;
  logic                        r_slow_armed;
  logic                        r_tick;

  logic                        w_step_press;

  cpu_state_t                  r_state;
  cpu_state_t                  w_state_next;
  logic                        r_cpu_en;
  logic                        w_cpu_en_next;
  logic [15:0]                 r_cycle_count;

  assign w_sync_in = {1'b1, halt, run_mode, slow_clk};

  generate
    if (SYNC_STAGES > 1) begin : g_sync_chain
      always_ff @(posedge clock_in or negedge reset_n) begin
        if (!reset_n) begin
          r_sync <= '0;
        end else begin
          r_sync <= {r_sync[SYNC_STAGES-2:0], w_sync_in};
        end
      end
    end else begin : g_sync_single
      always_ff @(posedge clock_in or negedge reset_n) begin
        if (!reset_n) begin
          r_sync <= '0;
        end else begin
          r_sync <= w_sync_in;
        end
      end
    end
  endgenerate

  assign {w_sync_valid, w_halt_s, w_run_s, w_slow_s} = r_sync[SYNC_STAGES-1];

  // Rising-edge detector on the synchronized slow clock. Edge detection is
  // armed only after a genuine low sample, and the tick is registered.
  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      r_slow_prev  <= 1'b0;
      r_slow_armed <= 1'b0;
      r_tick       <= 1'b0;
    end else begin
      r_slow_prev  <= w_slow_s;
      r_slow_armed <= r_slow_armed | (w_sync_valid & ~w_slow_s);
      r_tick       <= w_slow_s & ~r_slow_prev & r_slow_armed;
    end
  end

  btn_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .SYNC_STAGES     (SYNC_STAGES)
  ) u_btn_debounce (
    .clock_in  (clock_in),
    .reset_n   (reset_n),
    .btn_raw   (step_btn),
    .btn_press (w_step_press)
  );

  always_comb begin
    w_state_next = r_state;
    if (w_halt_s) begin
      w_state_next = HALTED;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_run_s) begin
            w_state_next = RUN;
          end else if (w_step_press) begin
            w_state_next = STEP_WAIT;
          end
        end
        RUN: begin
          if (!w_run_s) begin
            w_state_next = IDLE;
          end
        end
        STEP_WAIT: begin
          // Further presses are ignored; only the tick completes the step.
          if (r_tick) begin
            w_state_next = IDLE;
          end
        end
        HALTED: begin
          if (!w_run_s) begin
            w_state_next = IDLE;
          end
        end
        default: begin
          w_state_next = IDLE;
        end
      endcase
    end
  end

  // The enable is decided from the state held during the tick cycle, so a
  // tick that coincides with leaving RUN still issues its pulse. Ticks are
  // never adjacent, which keeps cpu_en from being high two cycles running.
  assign w_cpu_en_next = r_tick & ~w_halt_s &
                         ((r_state == RUN) | (r_state == STEP_WAIT));

  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= IDLE;
      r_cpu_en      <= 1'b0;
      r_cycle_count <= '0;
    end else begin
      r_state  <= w_state_next;
      r_cpu_en <= w_cpu_en_next;
      if (w_cpu_en_next) begin
        r_cycle_count <= r_cycle_count + 16'd1;
      end
    end
  end

  assign cpu_en      = r_cpu_en;
  assign cycle_count = r_cycle_count;
  assign state       = r_state;

endmodule : cpu_step_controller
`default_nettype wire
